sweep_gen: RTL and testbench

SWEEP_GEN -- requirements
Module: sweep_gen

---
 rtl/sweep_gen.sv | 143 ++++++++++++++
 tb/tb_sweep_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sweep_gen                                                     |
// | Purpose  : exhaustive stimulus sweep (binary up/down or Gray), each      |
// |            vector held HOLD cycles, with optional response signature.    |
// |            Optional: SWEEP_SIGNATURE_EN builds the CRC-16 signature reg. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sweep_gen #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             resp,
  output logic [WIDTH-1:0] pattern,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] vec_idx,
  output logic [15:0]      signature
);

  localparam int               c_hw        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [c_hw-1:0]  c_hold_last = c_hw'(HOLD - 1);
  localparam logic [WIDTH-1:0] c_idx_last  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [WIDTH-1:0] r_idx, w_idx_nxt;
  logic [c_hw-1:0]  r_hold, w_hold_nxt;
  logic             w_last;
  logic             w_sample;

  assign w_last = (r_hold == c_hold_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_sample    = 1'b0;
    valid       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_RUN;
          w_mode_nxt  = mode;
          w_idx_nxt   = '0;
          w_hold_nxt  = '0;
        end
      end
      S_RUN: begin
        valid = 1'b1;
        busy  = 1'b1;
        // abort leaves index, hold count and signature exactly as they were
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_sample   = 1'b1;
          w_hold_nxt = '0;
          if (r_idx == c_idx_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + WIDTH'(1);
          end
        end else begin
          w_hold_nxt = r_hold + c_hw'(1);
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pattern is derived from the held index, so it freezes whenever the index does
  always_comb begin
    pattern = r_idx;
    case (r_mode)
      2'b01:   pattern = ~r_idx;
      2'b10:   pattern = r_idx ^ (r_idx >> 1);
      default: pattern = r_idx;
    endcase
  end

  assign vec_idx = r_idx;

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] r_sig;
  logic        w_fb;

  assign w_fb = r_sig[15] ^ resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 16'h0000;
    end else if (r_state == S_IDLE && start && !abort) begin
      r_sig <= 16'h0000;
    end else if (w_sample) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign signature = r_sig;
`else
  logic w_unused_resp;
  assign w_unused_resp = resp ^ w_sample;
  assign signature     = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sweep_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sweep_gen                                                  |
// | Purpose  : randomized scoreboard bench for sweep_gen (WIDTH=3, HOLD=2).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sweep_gen;

  localparam int W  = 3;
  localparam int H  = 2;
  localparam int N  = 1 << W;
  localparam int NC = N * H;
`ifdef SWEEP_SIGNATURE_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         resp = 1'b0;
  logic [W-1:0] pattern;
  logic         valid;
  logic         busy;
  logic         done;
  logic [W-1:0] vec_idx;
  logic [15:0]  signature;

  sweep_gen #(.WIDTH(W), .HOLD(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .resp(resp), .pattern(pattern), .valid(valid), .busy(busy), .done(done),
    .vec_idx(vec_idx), .signature(signature)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] pat;
    logic [W-1:0] idx;
  } vec_t;

  vec_t        exp_vec[$];
  logic [15:0] exp_sig[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] model_pat(input int i, input logic [1:0] m);
    int v;
    case (m)
      2'b01:   v = (N - 1) - i;
      2'b10:   v = i ^ (i >> 1);
      default: v = i;
    endcase
    return v[W-1:0];
  endfunction

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic r);
    logic fb;
    fb = s[15] ^ r;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Monitor: every live vector and every done pulse consumes one expectation
  always @(negedge clk) begin
    vec_t        e;
    logic [15:0] s;
    if (rst_n) begin
      if (valid) begin
        if (exp_vec.size() == 0) begin
          check("valid_unexpected", valid, 0);
        end else begin
          e = exp_vec.pop_front();
          check("pattern", pattern, e.pat);
          check("vec_idx", vec_idx, e.idx);
          check("busy_in_run", busy, 1);
          check("done_in_run", done, 0);
        end
      end
      if (done) begin
        if (exp_sig.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          s = exp_sig.pop_front();
          check("signature_at_done", signature, s);
          check("valid_in_done", valid, 0);
        end
      end
    end
  end

  // ab_cyc/rst_cyc: RUN cycle at which abort/reset is applied, -1 for none
  task automatic run_sweep(input logic [1:0] m, input int ab_cyc, input int rst_cyc);
    bit          rv[NC];
    logic [15:0] sig;
    int          last_c;
    sig = 16'h0000;
    for (int c = 0; c < NC; c++) begin
      rv[c] = 1'($urandom_range(0, 1));
      if ((c % H) == H - 1 && (ab_cyc < 0 || c < ab_cyc)) sig = sig_step(sig, rv[c]);
    end
    last_c = (ab_cyc >= 0) ? ab_cyc : NC - 1;
    for (int c = 0; c <= last_c; c++) exp_vec.push_back({model_pat(c / H, m), W'(c / H)});
    if (ab_cyc < 0 && rst_cyc < 0) exp_sig.push_back(SIG_EN ? sig : 16'h0000);

    @(posedge clk) #1;
    start = 1'b1; mode = m; abort = 1'b0;
    @(posedge clk) #1;
    start = 1'b0;
    for (int c = 0; c < NC; c++) begin
      resp  = rv[c];
      mode  = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) == 0);
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check("rst_pattern", pattern, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec_idx", vec_idx, 0);
        check("rst_signature", signature, 0);
        exp_vec.delete();
        @(posedge clk) #1;
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        return;
      end
      if (c == ab_cyc) abort = 1'b1;
      if (c == 0) begin
        @(negedge clk);
        check("first_vector_latency", valid, 1);
      end
      @(posedge clk) #1;
      if (c == ab_cyc) begin
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pattern_hold", pattern, model_pat(c / H, m));
        check("abort_vec_idx_hold", vec_idx, c / H);
        check("abort_signature_frozen", signature, SIG_EN ? sig : 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        return;
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("done_after_run", done, 1);
    check("done_valid", valid, 0);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_pattern_hold", pattern, model_pat(N - 1, m));
    check("idle_vec_idx_hold", vec_idx, N - 1);
    check("idle_signature_hold", signature, SIG_EN ? sig : 16'h0000);
  endtask

  initial begin
    int ab;
    int rs;
    logic [1:0] m;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pattern", pattern, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_vec_idx", vec_idx, 0);
    check("reset_signature", signature, 0);
    rst_n = 1'b1;

    run_sweep(2'b00, -1, -1);
    run_sweep(2'b10, -1, -1);
    run_sweep(2'b01, -1, -1);
    run_sweep(2'b11, -1, -1);

    @(posedge clk) #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk) #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle_busy", busy, 0);
    check("start_abort_idle_valid", valid, 0);

    run_sweep(2'b00, 6 * H, -1);
    run_sweep(2'b10, 3 * H + H - 1, -1);
    run_sweep(2'b00, -1, 5 * H);
    run_sweep(2'b10, -1, -1);

    for (int k = 0; k < 10; k++) begin
      m  = 2'($urandom_range(0, 3));
      ab = -1;
      rs = -1;
      case ($urandom_range(0, 3))
        0:       ab = $urandom_range(0, NC - 1);
        1:       rs = $urandom_range(0, NC - 1);
        default: ;
      endcase
      run_sweep(m, ab, rs);
    end

    repeat (4) @(posedge clk);
    check("vec_queue_drained", exp_vec.size(), 0);
    check("sig_queue_drained", exp_sig.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
